sar_readout: RTL and testbench

Capture-and-transmit block on the receiving end of the SAR controller's output latch. It synchronises the controller's conversion-done strobe `CKO` into the system clock domain, captures the 8-bit conversion word on `DATA`, buffers it in a small FIFO and transmits each word off-chip over a 3-wire SPI-mode-0 link (`CS_N`/`SCK`/`SDO`). It decouples the asynchronous, conversion-paced ADC timing from a steady serial readout.

---
 rtl/sar_readout_pkg.sv | 23 ++
 rtl/sar_sync_fifo.sv | 91 +++++++++
 rtl/sar_readout.sv | 214 +++++++++++++++++++++
 tb/tb_sar_readout.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_readout_pkg.sv
// Shared definitions for the SAR readout block: data width, serializer
// state encoding, synchroniser depth and a small sizing helper.
package sar_readout_pkg;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } rd_state_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// Single-clock FIFO, DEPTH x WIDTH, with registered occupancy count.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   clr           synchronous flush (pointers and level to zero)
//   push, wdata   write request and data; ignored when full unless popping
//   pop, rdata    read request; rdata shows the head word combinationally
//   full, empty   occupancy flags derived from the pointers
//   level         registered number of stored words
module sar_sync_fifo
    import sar_readout_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      level_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // indices with differing wrap bits mean full.
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop & ~empty_s & ~clr;
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign do_push_s = push & ~clr & (~full_s | do_pop_s);

    assign rdata = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (do_push_s && !do_pop_s) begin
                level_r <= level_r + PTR_ONE;
            end else if (!do_push_s && do_pop_s) begin
                level_r <= level_r - PTR_ONE;
            end else begin
                level_r <= level_r;
            end
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/sar_readout.sv
// Captures SAR conversion words on the CKO strobe, buffers them and sends
// each word MSB-first over an SPI mode-0 link.
// Ports:
//   CLK, RST_N   system clock, asynchronous active-low reset
//   EN           block enable; low flushes the FIFO, OVF and any frame
//   CKO          asynchronous conversion-done strobe
//   DATA[0:7]    conversion word, DATA[0] is the MSB
//   CS_N/SCK/SDO serial link, SCK idles low
//   LEVEL        FIFO occupancy
//   OVF          sticky flag: a word was dropped on a full FIFO
module sar_readout
    import sar_readout_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SCK_DIV    = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         EN,
    input  logic                         CKO,
    input  logic [0:DATA_W-1]            DATA,
    output logic                         CS_N,
    output logic                         SCK,
    output logic                         SDO,
    output logic [$clog2(FIFO_DEPTH):0]  LEVEL,
    output logic                         OVF
);

    localparam int               DIV_W   = cnt_width(SCK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   cko_d_r;
    logic                   edge_s;
    logic                   push_r;
    logic [DATA_W-1:0]      cap_data_r;
    logic                   clr_s;
    logic                   full_s;
    logic                   empty_s;
    logic [DATA_W-1:0]      head_s;
    logic                   pop_s;
    logic                   ovf_r;

    rd_state_t              state_r, state_nxt_s;
    logic                   cs_n_r, cs_n_nxt_s;
    logic                   sck_r, sck_nxt_s;
    logic                   sdo_r, sdo_nxt_s;
    logic [DATA_W-1:0]      sr_r, sr_nxt_s;
    logic [2:0]             bit_r, bit_nxt_s;
    logic [DIV_W-1:0]       div_r, div_nxt_s;

    assign clr_s  = ~EN;
    assign edge_s = sync_r[SYNC_STAGES-1] & ~cko_d_r;

    // CKO synchroniser, edge-detect flop and capture register. The push is
    // registered so the FIFO write lands three edges after CKO is sampled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_r     <= {SYNC_STAGES{1'b0}};
            cko_d_r    <= 1'b0;
            push_r     <= 1'b0;
            cap_data_r <= {DATA_W{1'b0}};
        end else if (clr_s) begin
            sync_r     <= {SYNC_STAGES{1'b0}};
            cko_d_r    <= 1'b0;
            push_r     <= 1'b0;
            cap_data_r <= {DATA_W{1'b0}};
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], CKO};
            cko_d_r <= sync_r[SYNC_STAGES-1];
            push_r  <= edge_s;
            if (edge_s) begin
                cap_data_r <= DATA;   // DATA[0] lands in the MSB
            end else begin
                cap_data_r <= cap_data_r;
            end
        end
    end

    sar_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (clr_s),
        .push  (push_r),
        .pop   (pop_s),
        .wdata (cap_data_r),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (LEVEL)
    );

    // Sticky overflow: set only when a push meets a full FIFO with no pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_r <= 1'b0;
        end else if (clr_s) begin
            ovf_r <= 1'b0;
        end else if (push_r && full_s && !pop_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Serializer state and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            cs_n_r  <= 1'b1;
            sck_r   <= 1'b0;
            sdo_r   <= 1'b0;
            sr_r    <= {DATA_W{1'b0}};
            bit_r   <= 3'd0;
            div_r   <= {DIV_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cs_n_r  <= cs_n_nxt_s;
            sck_r   <= sck_nxt_s;
            sdo_r   <= sdo_nxt_s;
            sr_r    <= sr_nxt_s;
            bit_r   <= bit_nxt_s;
            div_r   <= div_nxt_s;
        end
    end

    // Serializer next-state: IDLE pops a word, SHIFT toggles SCK every
    // SCK_DIV cycles and advances SDO on falling edges, GAP holds CS_N high.
    always_comb begin
        state_nxt_s = state_r;
        cs_n_nxt_s  = cs_n_r;
        sck_nxt_s   = sck_r;
        sdo_nxt_s   = sdo_r;
        sr_nxt_s    = sr_r;
        bit_nxt_s   = bit_r;
        div_nxt_s   = div_r;
        pop_s       = 1'b0;
        if (!EN) begin
            state_nxt_s = IDLE;
            cs_n_nxt_s  = 1'b1;
            sck_nxt_s   = 1'b0;
            sdo_nxt_s   = 1'b0;
            sr_nxt_s    = {DATA_W{1'b0}};
            bit_nxt_s   = 3'd0;
            div_nxt_s   = {DIV_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        pop_s       = 1'b1;
                        sr_nxt_s    = head_s;
                        cs_n_nxt_s  = 1'b0;
                        sck_nxt_s   = 1'b0;
                        sdo_nxt_s   = head_s[DATA_W-1];
                        bit_nxt_s   = 3'd0;
                        div_nxt_s   = {DIV_W{1'b0}};
                        state_nxt_s = SHIFT;
                    end else begin
                        cs_n_nxt_s  = 1'b1;
                        sck_nxt_s   = 1'b0;
                        sdo_nxt_s   = 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_r == DIV_MAX) begin
                        div_nxt_s = {DIV_W{1'b0}};
                        if (!sck_r) begin
                            sck_nxt_s = 1'b1;
                        end else begin
                            sck_nxt_s = 1'b0;
                            // Counter wraps 7 -> 0 on the last falling edge.
                            bit_nxt_s = bit_r + 3'd1;
                            if (bit_r == 3'd7) begin
                                state_nxt_s = GAP;
                                cs_n_nxt_s  = 1'b1;
                                sdo_nxt_s   = 1'b0;
                            end else begin
                                sr_nxt_s  = {sr_r[DATA_W-2:0], 1'b0};
                                sdo_nxt_s = sr_r[DATA_W-2];
                            end
                        end
                    end else begin
                        div_nxt_s = div_r + DIV_ONE;
                    end
                end
                GAP: begin
                    if (div_r == DIV_MAX) begin
                        div_nxt_s   = {DIV_W{1'b0}};
                        state_nxt_s = IDLE;
                    end else begin
                        div_nxt_s = div_r + DIV_ONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cs_n_nxt_s  = 1'b1;
                    sck_nxt_s   = 1'b0;
                    sdo_nxt_s   = 1'b0;
                    div_nxt_s   = {DIV_W{1'b0}};
                end
            endcase
        end
    end

    assign CS_N = cs_n_r;
    assign SCK  = sck_r;
    assign SDO  = sdo_r;
    assign OVF  = ovf_r;

endmodule

// File: tb/tb_sar_readout.sv
// Directed bench for sar_readout (FIFO_DEPTH=4, SCK_DIV=2). A background
// monitor decodes completed SPI frames into queues; each test task drives
// stimulus and compares against hand-computed values.
module tb_sar_readout;

    localparam int FIFO_DEPTH = 4;
    localparam int SCK_DIV    = 2;

    logic                         clk;
    logic                         rst_n;
    logic                         en;
    logic                         cko;
    logic [0:7]                   data;
    logic                         cs_n;
    logic                         sck;
    logic                         sdo;
    logic [$clog2(FIFO_DEPTH):0]  level;
    logic                         ovf;

    int n_checks;
    int n_pass;

    logic [7:0] q_word[$];
    int         q_pulses[$];
    int         q_low[$];
    logic       mon_prev_sck;
    logic       mon_prev_csn;
    logic [7:0] mon_bits;
    int         mon_pulses;
    int         mon_low;

    sar_readout #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SCK_DIV    (SCK_DIV)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .EN    (en),
        .CKO   (cko),
        .DATA  (data),
        .CS_N  (cs_n),
        .SCK   (sck),
        .SDO   (sdo),
        .LEVEL (level),
        .OVF   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame decoder: sample on the falling CLK edge, record SDO at SCK rises.
    initial begin
        mon_prev_sck = 1'b0;
        mon_prev_csn = 1'b1;
        mon_bits     = 8'h00;
        mon_pulses   = 0;
        mon_low      = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mon_prev_sck = 1'b0;
                mon_prev_csn = 1'b1;
                mon_bits     = 8'h00;
                mon_pulses   = 0;
                mon_low      = 0;
            end else begin
                if (cs_n === 1'b0) begin
                    mon_low++;
                    if (sck === 1'b1 && mon_prev_sck === 1'b0) begin
                        mon_bits = {mon_bits[6:0], sdo};
                        mon_pulses++;
                    end
                end else if (mon_prev_csn === 1'b0) begin
                    q_word.push_back(mon_bits);
                    q_pulses.push_back(mon_pulses);
                    q_low.push_back(mon_low);
                    mon_bits   = 8'h00;
                    mon_pulses = 0;
                    mon_low    = 0;
                end
                mon_prev_sck = sck;
                mon_prev_csn = cs_n;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_queues();
        q_word.delete();
        q_pulses.delete();
        q_low.delete();
    endtask

    task automatic en_clear();
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && q_word.size() < n; i++) tick();
    endtask

    // Six CKO pulses two cycles apart carrying words 01..06; DATA is updated
    // one cycle after each rise so every word is held through its capture.
    task automatic do_burst();
        data = 8'h01;
        cko  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c <= 11) begin
                if (c % 2 == 1) begin
                    cko  = 1'b0;
                    data = 8'((c + 1) / 2);
                end else begin
                    cko = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", cs_n); else n_pass++;
        n_checks++; if (sck !== 1'b0) $display("FAIL reset_sck: got %b want 0", sck); else n_pass++;
        n_checks++; if (sdo !== 1'b0) $display("FAIL reset_sdo: got %b want 0", sdo); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_single();
        logic bad;
        clear_queues();
        bad  = 1'b0;
        data = 8'hA5;
        cko  = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 2) cko = 1'b0;
            if (level !== 3'd0 || cs_n !== 1'b1) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) $display("FAIL single_early: level/cs_n changed before capture"); else n_pass++;
        tick();
        n_checks++; if (level !== 3'd1) $display("FAIL single_level_up: got %0d want 1", level); else n_pass++;
        n_checks++; if (cs_n !== 1'b1) $display("FAIL single_cs_early: got %b want 1", cs_n); else n_pass++;
        tick();
        n_checks++; if (cs_n !== 1'b0) $display("FAIL single_cs_fall: got %b want 0", cs_n); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL single_level_down: got %0d want 0", level); else n_pass++;
        n_checks++; if (sdo !== 1'b1) $display("FAIL single_first_sdo: got %b want 1", sdo); else n_pass++;
        wait_frames(1, 100);
        n_checks++; if (q_word.size() !== 1) $display("FAIL single_frames: got %0d want 1", q_word.size()); else n_pass++;
        if (q_word.size() >= 1) begin
            n_checks++; if (q_word[0] !== 8'hA5) $display("FAIL single_word: got %h want a5", q_word[0]); else n_pass++;
            n_checks++; if (q_pulses[0] !== 8) $display("FAIL single_pulses: got %0d want 8", q_pulses[0]); else n_pass++;
            n_checks++; if (q_low[0] !== 16 * SCK_DIV) $display("FAIL single_cs_low: got %0d want %0d", q_low[0], 16 * SCK_DIV); else n_pass++;
        end
        idle(5);
    endtask

    task automatic test_burst();
        en_clear();
        clear_queues();
        do_burst();
        n_checks++; if (level !== 3'd4) $display("FAIL burst_level: got %0d want 4", level); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL burst_ovf: got %b want 1", ovf); else n_pass++;
        wait_frames(5, 300);
        n_checks++; if (q_word.size() < 5) $display("FAIL burst_frames: got %0d want 5", q_word.size()); else n_pass++;
        for (int i = 0; i < 5 && i < q_word.size(); i++) begin
            n_checks++; if (q_word[i] !== 8'(i + 1)) $display("FAIL burst_word%0d: got %h want %h", i, q_word[i], 8'(i + 1)); else n_pass++;
            n_checks++; if (q_pulses[i] !== 8) $display("FAIL burst_pulses%0d: got %0d want 8", i, q_pulses[i]); else n_pass++;
        end
        idle(60);
        n_checks++; if (q_word.size() !== 5) $display("FAIL burst_dropped: got %0d frames want 5", q_word.size()); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL burst_drained: got %0d want 0", level); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL burst_ovf_sticky: got %b want 1", ovf); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic bad;
        clear_queues();
        data = 8'h5A; cko = 1'b1;
        idle(2); cko = 1'b0; idle(2);
        data = 8'hC3; cko = 1'b1;
        idle(2); cko = 1'b0;
        for (int i = 0; i < 100 && mon_pulses < 3; i++) tick();
        n_checks++; if (mon_pulses !== 3) $display("FAIL rstmid_setup_pulses: got %0d want 3", mon_pulses); else n_pass++;
        n_checks++; if (level !== 3'd1 || ovf !== 1'b1) $display("FAIL rstmid_setup: level %0d ovf %b want 1 1", level, ovf); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (cs_n !== 1'b1) $display("FAIL rstmid_cs_n: got %b want 1", cs_n); else n_pass++;
        n_checks++; if (sck !== 1'b0) $display("FAIL rstmid_sck: got %b want 0", sck); else n_pass++;
        n_checks++; if (sdo !== 1'b0) $display("FAIL rstmid_sdo: got %b want 0", sdo); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL rstmid_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL rstmid_ovf: got %b want 0", ovf); else n_pass++;
        tick();
        #1 rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (cs_n !== 1'b1 || level !== 3'd0) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) $display("FAIL rstmid_resume: frame activity after reset"); else n_pass++;
        n_checks++; if (q_word.size() !== 0) $display("FAIL rstmid_frames: got %0d want 0", q_word.size()); else n_pass++;
    endtask

    task automatic test_pop_push_full();
        logic [7:0] exp_w [6];
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
        exp_w[3] = 8'h44; exp_w[4] = 8'h55; exp_w[5] = 8'h66;
        en_clear();
        clear_queues();
        data = 8'h11;
        cko  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 4 || c == 8 || c == 12 || c == 16 || c == 36) begin
                cko  = 1'b1;
                data = (c == 4) ? 8'h22 : (c == 8) ? 8'h33 : (c == 12) ? 8'h44 : (c == 16) ? 8'h55 : 8'h66;
            end else if (c == 2 || c == 6 || c == 10 || c == 14 || c == 18 || c == 38) begin
                cko = 1'b0;
            end
            if (c == 39) begin
                n_checks++; if (level !== 3'd4 || cs_n !== 1'b1) $display("FAIL full_setup: level %0d cs_n %b want 4 1", level, cs_n); else n_pass++;
            end
            if (c == 40) begin
                n_checks++; if (cs_n !== 1'b0) $display("FAIL full_cs_fall: got %b want 0", cs_n); else n_pass++;
                n_checks++; if (level !== 3'd4) $display("FAIL full_level: got %0d want 4", level); else n_pass++;
                n_checks++; if (ovf !== 1'b0) $display("FAIL full_ovf: got %b want 0", ovf); else n_pass++;
            end
        end
        wait_frames(6, 300);
        n_checks++; if (q_word.size() < 6) $display("FAIL full_frames: got %0d want 6", q_word.size()); else n_pass++;
        for (int i = 0; i < 6 && i < q_word.size(); i++) begin
            n_checks++; if (q_word[i] !== exp_w[i]) $display("FAIL full_word%0d: got %h want %h", i, q_word[i], exp_w[i]); else n_pass++;
        end
        n_checks++; if (ovf !== 1'b0) $display("FAIL full_ovf_end: got %b want 0", ovf); else n_pass++;
    endtask

    task automatic test_en_clear();
        logic bad;
        en_clear();
        clear_queues();
        do_burst();
        for (int i = 0; i < 100 && !(level === 3'd3 && cs_n === 1'b0); i++) tick();
        idle(5);
        n_checks++; if (level !== 3'd3 || ovf !== 1'b1 || cs_n !== 1'b0) $display("FAIL en_setup: level %0d ovf %b cs_n %b want 3 1 0", level, ovf, cs_n); else n_pass++;
        en   = 1'b0;
        cko  = 1'b1;
        data = 8'h99;
        tick();
        en  = 1'b1;
        cko = 1'b0;
        n_checks++; if (cs_n !== 1'b1) $display("FAIL en_cs_n: got %b want 1", cs_n); else n_pass++;
        n_checks++; if (sck !== 1'b0) $display("FAIL en_sck: got %b want 0", sck); else n_pass++;
        n_checks++; if (sdo !== 1'b0) $display("FAIL en_sdo: got %b want 0", sdo); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL en_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL en_ovf: got %b want 0", ovf); else n_pass++;
        tick();
        clear_queues();
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cs_n !== 1'b1 || level !== 3'd0) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) $display("FAIL en_ignored_edge: activity after clear"); else n_pass++;
        n_checks++; if (q_word.size() !== 0) $display("FAIL en_frames_after_clear: got %0d want 0", q_word.size()); else n_pass++;
        data = 8'h3C;
        cko  = 1'b1;
        idle(2);
        cko = 1'b0;
        wait_frames(1, 100);
        n_checks++; if (q_word.size() !== 1) $display("FAIL en_next_frames: got %0d want 1", q_word.size()); else n_pass++;
        if (q_word.size() >= 1) begin
            n_checks++; if (q_word[0] !== 8'h3C) $display("FAIL en_next_word: got %h want 3c", q_word[0]); else n_pass++;
            n_checks++; if (q_pulses[0] !== 8) $display("FAIL en_next_pulses: got %0d want 8", q_pulses[0]); else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        cko      = 1'b0;
        data     = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_reset_mid_frame();
        test_pop_push_full();
        test_en_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
